switch_word_loader: RTL and testbench

Switch-driven program loader for the MIPS test system: the input-side counterpart of the LED/seven-segment debug path. The operator dials bytes on `data_switches` and presses the load button. The block assembles four bytes into a 32-bit big-endian word, writes it into instruction/data memory through a request/acknowledge port, and auto-increments the word address. It holds the CPU stalled while loading and exports address, byte position and status for the display controller and LEDs.

---
 rtl/switch_word_loader.sv | 136 +++++++++++++
 tb/tb_switch_word_loader.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_word_loader.sv
// Switch-driven program loader: assembles four dialled bytes into a big-endian word,
// writes it to memory over a req/ack port, auto-increments the address and stalls the CPU.
module switch_word_loader #(
  parameter int                ADDR_W     = 6,
  parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
  input  logic              clk_50MHz,
  input  logic              reset,
  input  logic              enable,
  input  logic              load_pulse,
  input  logic              addr_set_pulse,
  input  logic [7:0]        data_switches,
  input  logic              mem_ack,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic [1:0]        byte_idx,
  output logic              full,
  output logic              drop_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_FULL
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        idx_q, idx_d;
  logic              we_q, we_d;
  logic              hold_q, hold_d;
  logic              full_q, full_d;
  logic              drop_q, drop_d;
  logic [1:0]        lane;

  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= START_ADDR;
      wdata_q <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      hold_q  <= 1'b0;
      full_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      hold_q  <= hold_d;
      full_q  <= full_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    idx_d   = idx_q;
    full_d  = full_q;
    drop_d  = drop_q;
    lane    = 2'd3 - idx_q;

    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_COLLECT;
      end

      S_COLLECT: begin
        // Address set outranks a coincident byte, which is then reported as dropped
        if (!enable) begin
          idx_d   = '0;
          wdata_d = '0;
          state_d = S_IDLE;
        end else if (addr_set_pulse) begin
          addr_d  = data_switches[ADDR_W-1:0];
          idx_d   = '0;
          wdata_d = '0;
          if (load_pulse) drop_d = 1'b1;
        end else if (load_pulse) begin
          wdata_d[{lane, 3'b000} +: 8] = data_switches;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = S_WRITE;
        end
      end

      S_WRITE: begin
        if (load_pulse || addr_set_pulse) drop_d = 1'b1;
        if (mem_ack) begin
          if (addr_q == '1) begin
            full_d  = 1'b1;
            state_d = S_FULL;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = enable ? S_COLLECT : S_IDLE;
          end
        end
      end

      S_FULL: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else begin
          if (load_pulse) drop_d = 1'b1;
          if (addr_set_pulse) begin
            addr_d  = data_switches[ADDR_W-1:0];
            wdata_d = '0;
            full_d  = 1'b0;
            state_d = S_COLLECT;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    we_d   = (state_d == S_WRITE);
    hold_d = (state_d != S_IDLE);
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_hold  = hold_q;
  assign byte_idx  = idx_q;
  assign full      = full_q;
  assign drop_err  = drop_q;

endmodule

// File: tb/tb_switch_word_loader.sv
// Bench for switch_word_loader: directed scenarios plus randomized operator activity,
// every cycle compared against a word-level behavioural model of the loader.
module tb_switch_word_loader;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 1 << ADDR_W;

  localparam int M_IDLE    = 0;
  localparam int M_COLLECT = 1;
  localparam int M_WRITE   = 2;
  localparam int M_FULL    = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b0;
  logic              loadPulse = 1'b0;
  logic              addrSetPulse = 1'b0;
  logic [7:0]        dataSwitches = 8'h00;
  logic              memAck = 1'b1;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [31:0]       memWdata;
  logic              cpuHold;
  logic [1:0]        byteIdx;
  logic              fullFlag;
  logic              dropErr;

  int errors = 0;
  int checks = 0;
  bit checkOn = 1'b0;

  int          mMode, mAddr, mCount;
  logic [31:0] mWord;
  bit          mWe, mHold, mFull, mDrop;
  int          nMode, nAddr, nCount;
  logic [31:0] nWord;
  bit          nFull, nDrop;

  switch_word_loader #(.ADDR_W(ADDR_W), .START_ADDR('0)) dut (
    .clk_50MHz     (clk),
    .reset         (reset),
    .enable        (enable),
    .load_pulse    (loadPulse),
    .addr_set_pulse(addrSetPulse),
    .data_switches (dataSwitches),
    .mem_ack       (memAck),
    .mem_we        (memWe),
    .mem_addr      (memAddr),
    .mem_wdata     (memWdata),
    .cpu_hold      (cpuHold),
    .byte_idx      (byteIdx),
    .full          (fullFlag),
    .drop_err      (dropErr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mMode = M_IDLE; mAddr = 0; mCount = 0; mWord = 32'h0;
    mWe = 1'b0; mHold = 1'b0; mFull = 1'b0; mDrop = 1'b0;
  endtask

  // Next model state from the loader rules, using the inputs that will be seen at the coming edge
  task automatic modelNext();
    int shift;
    nMode = mMode; nAddr = mAddr; nCount = mCount; nWord = mWord;
    nFull = mFull; nDrop = mDrop;
    case (mMode)
      M_IDLE: if (enable) nMode = M_COLLECT;
      M_COLLECT: begin
        if (!enable) begin
          nCount = 0; nWord = 0; nMode = M_IDLE;
        end else if (addrSetPulse) begin
          nAddr = int'(dataSwitches) % DEPTH; nCount = 0; nWord = 0;
          if (loadPulse) nDrop = 1'b1;
        end else if (loadPulse) begin
          shift = 8 * (3 - mCount);
          nWord = (mWord & ~(32'hFF << shift)) | (32'(dataSwitches) << shift);
          nCount = mCount + 1;
          if (nCount == 4) begin
            nCount = 0; nMode = M_WRITE;
          end
        end
      end
      M_WRITE: begin
        if (loadPulse || addrSetPulse) nDrop = 1'b1;
        if (memAck) begin
          if (mAddr == DEPTH - 1) begin
            nFull = 1'b1; nMode = M_FULL;
          end else begin
            nAddr = mAddr + 1;
            nMode = enable ? M_COLLECT : M_IDLE;
          end
        end
      end
      default: begin
        if (!enable) nMode = M_IDLE;
        else begin
          if (loadPulse) nDrop = 1'b1;
          if (addrSetPulse) begin
            nAddr = int'(dataSwitches) % DEPTH; nWord = 0; nFull = 1'b0; nMode = M_COLLECT;
          end
        end
      end
    endcase
  endtask

  task automatic tick();
    modelNext();
    @(posedge clk);
    mMode = nMode; mAddr = nAddr; mCount = nCount; mWord = nWord;
    mFull = nFull; mDrop = nDrop;
    mWe = (nMode == M_WRITE);
    mHold = (nMode != M_IDLE);
    #1;
  endtask

  task automatic applyStimulus(input bit ld, input bit as, input logic [7:0] sw);
    loadPulse = ld; addrSetPulse = as; dataSwitches = sw;
    tick();
    loadPulse = 1'b0; addrSetPulse = 1'b0;
  endtask

  task automatic resetDut();
    reset = 1'b1;
    modelReset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic loadWord(input logic [31:0] w);
    for (int b = 0; b < 4; b++) begin
      applyStimulus(1'b1, 1'b0, w[31-8*b -: 8]);
      if (b < 3) applyStimulus(1'b0, 1'b0, 8'h00);
    end
  endtask

  always @(negedge clk) begin
    if (checkOn) begin
      checkOutput("mem_we", 32'(memWe), 32'(mWe));
      checkOutput("mem_addr", 32'(memAddr), 32'(mAddr));
      checkOutput("mem_wdata", memWdata, mWord);
      checkOutput("cpu_hold", 32'(cpuHold), 32'(mHold));
      checkOutput("byte_idx", 32'(byteIdx), 32'(mCount));
      checkOutput("full", 32'(fullFlag), 32'(mFull));
      checkOutput("drop_err", 32'(dropErr), 32'(mDrop));
    end
  end

  initial begin
    int  gap;
    int  r;
    modelReset();
    checkOn = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset_we", 32'(memWe), 32'h0);
    checkOutput("reset_addr", 32'(memAddr), 32'h0);
    checkOutput("reset_hold", 32'(cpuHold), 32'h0);
    reset = 1'b0;

    // Basic word at address 0
    memAck = 1'b1; enable = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("hold_rise", 32'(cpuHold), 32'h1);
    loadWord(32'h12345678);
    checkOutput("w1_we", 32'(memWe), 32'h1);
    checkOutput("w1_addr", 32'(memAddr), 32'h0);
    checkOutput("w1_wdata", memWdata, 32'h12345678);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("w1_we_drop", 32'(memWe), 32'h0);
    checkOutput("w1_addr_inc", 32'(memAddr), 32'h1);
    checkOutput("w1_idx", 32'(byteIdx), 32'h0);

    // Top of memory, full flag and dropped load
    applyStimulus(1'b0, 1'b1, 8'h3E);
    applyStimulus(1'b0, 1'b0, 8'h00);
    loadWord(32'hCAFEF00D);
    checkOutput("w3e_addr", 32'(memAddr), 32'h3E);
    applyStimulus(1'b0, 1'b0, 8'h00);
    loadWord(32'hA5A55A5A);
    checkOutput("w3f_addr", 32'(memAddr), 32'h3F);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("full_set", 32'(fullFlag), 32'h1);
    checkOutput("full_addr", 32'(memAddr), 32'h3F);
    applyStimulus(1'b1, 1'b0, 8'hAA);
    checkOutput("full_drop", 32'(dropErr), 32'h1);
    checkOutput("full_no_we", 32'(memWe), 32'h0);
    applyStimulus(1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("full_clear", 32'(fullFlag), 32'h0);
    checkOutput("full_addr0", 32'(memAddr), 32'h0);
    applyStimulus(1'b0, 1'b0, 8'h00);

    // Delayed ack with a load during the stall
    resetDut();
    memAck = 1'b0; enable = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00);
    loadWord(32'hDEADBEEF);
    applyStimulus(1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h99);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("stall_we", 32'(memWe), 32'h1);
    checkOutput("stall_wdata", memWdata, 32'hDEADBEEF);
    checkOutput("stall_addr", 32'(memAddr), 32'h0);
    checkOutput("stall_drop", 32'(dropErr), 32'h1);
    memAck = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("stall_we_end", 32'(memWe), 32'h0);
    applyStimulus(1'b1, 1'b0, 8'h11);
    checkOutput("next_idx", 32'(byteIdx), 32'h1);
    applyStimulus(1'b0, 1'b0, 8'h00);

    // Enable drop mid-word discards the partial word
    applyStimulus(1'b1, 1'b0, 8'h22);
    applyStimulus(1'b0, 1'b0, 8'h00);
    enable = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("abort_idx", 32'(byteIdx), 32'h0);
    checkOutput("abort_wdata", memWdata, 32'h0);
    checkOutput("abort_hold", 32'(cpuHold), 32'h0);
    enable = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("reenable_addr", 32'(memAddr), 32'h1);

    // Simultaneous load and address set
    resetDut();
    enable = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h77);
    applyStimulus(1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b1, 8'h05);
    checkOutput("both_addr", 32'(memAddr), 32'h5);
    checkOutput("both_idx", 32'(byteIdx), 32'h0);
    checkOutput("both_drop", 32'(dropErr), 32'h1);
    applyStimulus(1'b0, 1'b0, 8'h00);

    // Asynchronous reset in the middle of a write
    memAck = 1'b0;
    loadWord(32'h01020304);
    checkOutput("pre_reset_we", 32'(memWe), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput("async_we", 32'(memWe), 32'h0);
    checkOutput("async_addr", 32'(memAddr), 32'h0);
    checkOutput("async_wdata", memWdata, 32'h0);
    checkOutput("async_hold", 32'(cpuHold), 32'h0);
    checkOutput("async_drop", 32'(dropErr), 32'h0);
    #3;
    reset = 1'b0;

    // Randomized operator activity
    gap = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 29) == 0) enable = ~enable;
      memAck = ($urandom_range(0, 3) != 0);
      if (gap == 0 && $urandom_range(0, 2) == 0) begin
        r = $urandom_range(0, 15);
        if (r < 12) applyStimulus(1'b1, 1'b0, 8'($urandom));
        else if (r < 14) applyStimulus(1'b0, 1'b1, ($urandom_range(0, 1) == 0) ? 8'h3E : 8'($urandom));
        else applyStimulus(1'b1, 1'b1, 8'($urandom));
        gap = 1;
      end else begin
        applyStimulus(1'b0, 1'b0, 8'($urandom));
        gap = 0;
      end
    end

    checkOn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
